sifh_peak_find: RTL and testbench

SIFH_PEAK_FIND -- requirements
Module: sifh_peak_find

---
 rtl/sifh_peak_find_pkg.sv | 8 +
 rtl/sifh_max_cmp.sv | 35 +++
 rtl/sifh_peak_find.sv | 117 +++++++++++
 tb/tb_sifh_peak_find.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sifh_peak_find_pkg.sv
// sifh_peak_find_pkg: shared histogram geometry defaults and scan state encoding
package sifh_peak_find_pkg;
  localparam int BIN_NUM_PER_HIS = 16;
  localparam int PIXEL_NUM_PER_RAM = 4;
  localparam int peakMax = 8;
  localparam int RAM_ADDR = $clog2(PIXEL_NUM_PER_RAM) + $clog2(BIN_NUM_PER_HIS);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;
endpackage

// File: rtl/sifh_max_cmp.sv
// sifh_max_cmp: running maximum per pixel; lowest bin wins ties, bin 0 loads unconditionally
module sifh_max_cmp #(
  parameter int NB = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [NB-1:0]    bin,
  input  logic [CNT_W-1:0] cnt,
  output logic [NB-1:0]    max_bin,
  output logic [CNT_W-1:0] max_cnt
);
  logic [NB-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic take;
  // outputs expose the merged value so the final bin of a pixel is visible in its own data cycle
  always_comb begin
    take = en && (load || cnt > cnt_q);
    bin_d = take ? bin : bin_q;
    cnt_d = take ? cnt : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      cnt_q <= cnt_d;
    end
  end
  assign max_bin = bin_d;
  assign max_cnt = cnt_d;
endmodule

// File: rtl/sifh_peak_find.sv
// sifh_peak_find: scans a histogram RAM after acquisition and reports the peak bin of every pixel
module sifh_peak_find
  import sifh_peak_find_pkg::*;
#(
  parameter int BIN_NUM = BIN_NUM_PER_HIS,
  parameter int PIX_NUM = PIXEL_NUM_PER_RAM,
  parameter int CNT_W = peakMax,
  parameter int CLEAR_ON_READ = 1,
  localparam int NB = $clog2(BIN_NUM),
  localparam int NP = $clog2(PIX_NUM),
  localparam int ADDR_W = NP + NB
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  output logic              rEnable,
  input  logic [CNT_W-1:0]  counts,
  output logic [ADDR_W-1:0] waddr,
  output logic              wEnable,
  output logic [CNT_W-1:0]  wdata,
  output logic              peak_valid,
  output logic [NP-1:0]     peak_pix,
  output logic [NB-1:0]     peak_bin,
  output logic [CNT_W-1:0]  peak_cnt
);
  state_e state_q, state_d;
  logic [NB-1:0] rbin_q, rbin_d;
  logic [NP-1:0] rpix_q, rpix_d;
  logic ren_q, ren_d;
  logic [ADDR_W-1:0] addr_d_q;
  logic dv_q;
  logic done_q, done_d;
  logic pv_q, pv_d;
  logic [NP-1:0] pix_q, pix_d;
  logic [NB-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0] d_bin, max_bin;
  logic [NP-1:0] d_pix;
  logic [CNT_W-1:0] max_cnt;
  assign d_bin = addr_d_q[NB-1:0];
  assign d_pix = addr_d_q[ADDR_W-1:NB];
  sifh_max_cmp #(.NB(NB), .CNT_W(CNT_W)) u_max (
    .clk(clk),
    .rst(res),
    .load(d_bin == '0),
    .en(dv_q),
    .bin(d_bin),
    .cnt(counts),
    .max_bin(max_bin),
    .max_cnt(max_cnt)
  );
  always_comb begin
    state_d = state_q;
    ren_d = 1'b0;
    rbin_d = rbin_q;
    rpix_d = rpix_q;
    if (state_q == IDLE && start) begin
      state_d = SCAN;
      ren_d = 1'b1;
      rbin_d = '0;
      rpix_d = '0;
    end else if (state_q == SCAN) begin
      rbin_d = rbin_q + 1'b1;
      rpix_d = rbin_q == '1 ? rpix_q + 1'b1 : rpix_q;
      ren_d = !(rbin_q == '1 && rpix_q == '1);
      state_d = ren_d ? SCAN : DRAIN;
    end else if (state_q == DRAIN && done_q) begin
      state_d = IDLE;
    end
    pv_d = dv_q && d_bin == '1;
    done_d = pv_d && d_pix == '1;
    pix_d = pv_d ? d_pix : pix_q;
    bin_d = pv_d ? max_bin : bin_q;
    cnt_d = pv_d ? max_cnt : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      rbin_q <= '0;
      rpix_q <= '0;
      ren_q <= 1'b0;
      addr_d_q <= '0;
      dv_q <= 1'b0;
      done_q <= 1'b0;
      pv_q <= 1'b0;
      pix_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rbin_q <= rbin_d;
      rpix_q <= rpix_d;
      ren_q <= ren_d;
      addr_d_q <= {rpix_q, rbin_q};
      dv_q <= ren_q;
      done_q <= done_d;
      pv_q <= pv_d;
      pix_q <= pix_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign raddr = {rpix_q, rbin_q};
  assign rEnable = ren_q;
  assign waddr = addr_d_q;
  assign wEnable = (CLEAR_ON_READ != 0) && dv_q;
  assign wdata = '0;
  assign peak_valid = pv_q;
  assign peak_pix = pix_q;
  assign peak_bin = bin_q;
  assign peak_cnt = cnt_q;
endmodule

// File: tb/tb_sifh_peak_find.sv
// tb_sifh_peak_find: directed frames against a 1-cycle RAM model, scoreboard on peak results
module tb_sifh_peak_find;
  logic clk, res, start;
  logic busy, done, rEnable, wEnable, peak_valid;
  logic [5:0] raddr, waddr;
  logic [7:0] counts, wdata, peak_cnt;
  logic [1:0] peak_pix;
  logic [3:0] peak_bin;
  logic [7:0] mem [64];
  logic ld_en;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  typedef struct {int pix; int bin; int cnt; int cyc; bit dn;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, nwr = 0;
  longint t0 = 0;
  logic prev_ren = 0;
  logic [5:0] prev_raddr = 0;

  sifh_peak_find dut (
    .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .rEnable(rEnable), .counts(counts),
    .waddr(waddr), .wEnable(wEnable), .wdata(wdata),
    .peak_valid(peak_valid), .peak_pix(peak_pix), .peak_bin(peak_bin), .peak_cnt(peak_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wEnable) mem[waddr] <= wdata;
    if (rEnable) counts <= mem[raddr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (peak_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_peak: got peak_valid=1 expected 0 at t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("peak_pix", peak_pix, e.pix);
        chk("peak_bin", peak_bin, e.bin);
        chk("peak_cnt", peak_cnt, e.cnt);
        chk("peak_cycle", ($time - t0 - 5) / 10 + 1, e.cyc);
        chk("done_with_peak", done, e.dn);
      end
    end else if (done) begin
      chk("done_without_peak", done, 0);
    end
    if (wEnable) begin
      nwr++;
      chk("wdata", wdata, 0);
      chk("waddr", waddr, prev_ren ? prev_raddr : 6'h3f ^ waddr);
    end
    prev_ren = rEnable;
    prev_raddr = raddr;
  end

  task automatic load(input int a, input int d);
    @(negedge clk);
    ld_en = 1;
    ld_addr = 6'(a);
    ld_data = 8'(d);
    @(posedge clk);
    #1 ld_en = 0;
  endtask

  task automatic push_frame(input int b[4], input int c[4]);
    for (int p = 0; p < 4; p++) q.push_back('{p, b[p], c[p], 16 * p + 18, p == 3});
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    t0 = $time;
    #1 start = 0;
    @(negedge clk);
    chk("first_rEnable", rEnable, 1);
    chk("first_raddr", raddr, 0);
    chk("first_busy", busy, 1);
  endtask

  task automatic finish_frame();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("frame_drain", q.size(), 0);
    chk("busy_idle", busy, 0);
    q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, done, rEnable, wEnable, peak_valid, raddr, waddr, wdata, peak_pix, peak_bin, peak_cnt}, 0);
  endtask

  task automatic chk_ram_clear();
    int nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != 0) nz++;
    chk("ram_clear", nz, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1;
    start = 0;
    ld_en = 0;
    ld_addr = 0;
    ld_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    res = 0;
    for (int i = 0; i < 64; i++) load(i, 0);
    // single peak per pixel, second start mid-scan, then back-to-back frame
    for (int p = 0; p < 4; p++) load(p * 16 + 3 * p + 1, 10 + p);
    push_frame('{1, 4, 7, 10}, '{10, 11, 12, 13});
    nwr = 0;
    pulse_start();
    repeat (19) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (46) @(posedge clk);
    #1;
    chk("frame1_queue", q.size(), 0);
    chk("frame1_writes", nwr, 64);
    chk("idle_after_done", busy, 0);
    nwr = 0;
    push_frame('{0, 0, 0, 0}, '{0, 0, 0, 0});
    pulse_start();
    finish_frame();
    chk("zero_frame_writes", nwr, 64);
    chk_ram_clear();
    // tie between bins 5 and 9
    load(5, 200);
    load(9, 200);
    push_frame('{5, 0, 0, 0}, '{200, 0, 0, 0});
    pulse_start();
    finish_frame();
    // full-scale count above near-full neighbours
    for (int b = 0; b < 16; b++) load(32 + b, b == 15 ? 255 : 254);
    push_frame('{0, 0, 15, 0}, '{0, 0, 255, 0});
    pulse_start();
    finish_frame();
    chk_ram_clear();
    // reset mid-scan
    for (int p = 0; p < 4; p++) load(p * 16 + 3 * p + 1, 10 + p);
    q.push_back('{0, 1, 10, 18, 0});
    pulse_start();
    repeat (29) @(posedge clk);
    #1 res = 1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort_outputs");
    res = 0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("abort_queue", q.size(), 0);
    chk("abort_idle", busy, 0);
    for (int p = 0; p < 4; p++) load(p * 16 + 3 * p + 1, 10 + p);
    push_frame('{1, 4, 7, 10}, '{10, 11, 12, 13});
    pulse_start();
    finish_frame();
    chk_ram_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
